// File: rtl/systolic_tile_scheduler.sv
// rtl/systolic_tile_scheduler.sv - buffers one tile, feeds it skewed into a systolic array, replays results
module systolic_tile_scheduler #(
    parameter int SIZE         = 3,
    parameter int DATA_SIZE    = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_SIZE*SIZE-1:0] in_data,
    output logic [DATA_SIZE*SIZE-1:0] sa_a,
    output logic [DATA_SIZE*SIZE-1:0] sa_b,
    output logic                      sa_reset_counter,
    input  logic [DATA_SIZE*SIZE-1:0] sa_c,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_SIZE*SIZE-1:0] out_data,
    output logic                      busy
);
    localparam int CW = $clog2(2*SIZE + DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_LAST  = CW'(2*SIZE - 1);
    localparam logic [CW-1:0] FEED_LAST  = CW'(2*SIZE - 2);
    localparam logic [CW-1:0] DRAIN_LAST = CW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [CW-1:0] ROW_LAST   = CW'(SIZE - 1);

    typedef enum logic [2:0] {LOAD, FEED, DRAIN, CAPTURE, OUT} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [DATA_SIZE-1:0]   a_buf   [SIZE][SIZE];
    logic [DATA_SIZE-1:0]   b_buf   [SIZE][SIZE];
    logic [DATA_SIZE-1:0]   res_buf [SIZE][SIZE];
    logic [CW-1:0]          next_k;
    logic [DATA_SIZE*SIZE-1:0] skew_a;
    logic [DATA_SIZE*SIZE-1:0] skew_b;

    // Skewed lane values for the feed cycle about to be entered (k=0 from LOAD, cnt+1 inside FEED)
    always_comb begin
        next_k = (state == LOAD) ? '0 : cnt + 1'b1;
        skew_a = '0;
        skew_b = '0;
        for (int j = 0; j < SIZE; j++) begin
            for (int e = 0; e < SIZE; e++) begin
                if (int'(next_k) == j + e) begin
                    skew_a[DATA_SIZE*(SIZE-j)-1 -: DATA_SIZE] = a_buf[j][e];
                    skew_b[DATA_SIZE*(SIZE-j)-1 -: DATA_SIZE] = b_buf[j][e];
                end
            end
        end
    end

    // Result row selected by the replay counter; only meaningful while out_valid is high
    always_comb begin
        out_data = '0;
        for (int r = 0; r < SIZE; r++) begin
            if (cnt == CW'(r)) begin
                for (int e = 0; e < SIZE; e++) begin
                    out_data[DATA_SIZE*(SIZE-e)-1 -: DATA_SIZE] = res_buf[r][e];
                end
            end
        end
    end

    assign busy = !((state == LOAD) && (cnt == '0));

    // Tile sequencer: state, shared beat counter, buffers and registered array/handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= LOAD;
            cnt              <= '0;
            in_ready         <= 1'b1;
            out_valid        <= 1'b0;
            sa_a             <= '0;
            sa_b             <= '0;
            sa_reset_counter <= 1'b0;
            for (int r = 0; r < SIZE; r++) begin
                for (int e = 0; e < SIZE; e++) begin
                    a_buf[r][e]   <= '0;
                    b_buf[r][e]   <= '0;
                    res_buf[r][e] <= '0;
                end
            end
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        for (int r = 0; r < SIZE; r++) begin
                            for (int e = 0; e < SIZE; e++) begin
                                if (cnt == CW'(r))
                                    a_buf[r][e] <= in_data[DATA_SIZE*(SIZE-e)-1 -: DATA_SIZE];
                                if (cnt == CW'(SIZE + r))
                                    b_buf[r][e] <= in_data[DATA_SIZE*(SIZE-e)-1 -: DATA_SIZE];
                            end
                        end
                        if (cnt == LOAD_LAST) begin
                            // Column SIZE-1 of B is first used at k=SIZE-1, so k=0 never needs the beat being written
                            state            <= FEED;
                            cnt              <= '0;
                            in_ready         <= 1'b0;
                            sa_a             <= skew_a;
                            sa_b             <= skew_b;
                            sa_reset_counter <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FEED: begin
                    sa_reset_counter <= 1'b0;
                    if (cnt == FEED_LAST) begin
                        state <= (DRAIN_CYCLES == 0) ? CAPTURE : DRAIN;
                        cnt   <= '0;
                        sa_a  <= '0;
                        sa_b  <= '0;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        sa_a <= skew_a;
                        sa_b <= skew_b;
                    end
                end
                DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state <= CAPTURE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    for (int r = 0; r < SIZE; r++) begin
                        for (int e = 0; e < SIZE; e++) begin
                            if (cnt == CW'(r))
                                res_buf[r][e] <= sa_c[DATA_SIZE*(SIZE-e)-1 -: DATA_SIZE];
                        end
                    end
                    if (cnt == ROW_LAST) begin
                        state     <= OUT;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        if (cnt == ROW_LAST) begin
                            state     <= LOAD;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= LOAD;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// tb/tb_systolic_tile_scheduler.sv - self-checking bench for systolic_tile_scheduler
module tb_systolic_tile_scheduler;
    localparam int S  = 3;
    localparam int DW = 16;
    localparam int DC = 3;
    localparam int W  = S*DW;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [W-1:0] sa_a;
    logic [W-1:0] sa_b;
    logic         sa_reset_counter;
    logic [W-1:0] sa_c;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] ma [S][S];
    logic [DW-1:0] mb [S][S];
    logic [W-1:0]  exp_row [S];

    systolic_tile_scheduler #(.SIZE(S), .DATA_SIZE(DW), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .sa_a(sa_a), .sa_b(sa_b), .sa_reset_counter(sa_reset_counter), .sa_c(sa_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One cycle: wake at the falling edge, present a fresh random array result word
    task automatic step();
        @(negedge clk);
        sa_c = {16'($urandom), 16'($urandom), 16'($urandom)};
    endtask

    function automatic logic [W-1:0] pack_row(input logic [DW-1:0] l0, input logic [DW-1:0] l1,
                                              input logic [DW-1:0] l2);
        return {l0, l1, l2};
    endfunction

    // Expected skewed feed word at feed cycle k: lane j carries element k-j of row/column j
    function automatic logic [W-1:0] feed_exp(input int k, input bit use_b);
        logic [DW-1:0] lane [S];
        for (int j = 0; j < S; j++) begin
            lane[j] = '0;
            if (k - j >= 0 && k - j < S) lane[j] = use_b ? mb[j][k-j] : ma[j][k-j];
        end
        return pack_row(lane[0], lane[1], lane[2]);
    endfunction

    task automatic run_tile(input bit directed, input bit toggle, input bit garbage,
                            input int stall, input int reset_rel);
        int bi;
        int lc;
        int r;
        int oc;
        bit v;
        for (int i = 0; i < S; i++) begin
            for (int e = 0; e < S; e++) begin
                ma[i][e] = directed ? DW'(i*S + e + 1) : DW'($urandom);
                mb[i][e] = directed ? ((i == e) ? 16'd1 : 16'd0) : DW'($urandom);
            end
        end
        bi = 0;
        lc = 0;
        while (bi < 2*S && lc < 100) begin
            step();
            lc++;
            if (lc == 1) begin
                chk("load_ready", in_ready, 1);
                chk("idle_busy", busy, 0);
            end
            v = toggle ? ((lc % 2) == 1) : 1'b1;
            in_valid = v;
            if (bi < S) in_data = pack_row(ma[bi][0], ma[bi][1], ma[bi][2]);
            else        in_data = pack_row(mb[bi-S][0], mb[bi-S][1], mb[bi-S][2]);
            if (v && in_ready) bi++;
        end
        chk("load_beats", bi, 2*S);
        if (toggle) chk("load_cycles", lc, 4*S - 1);
        for (int rel = 1; rel <= 2*S - 1 + DC + S; rel++) begin
            step();
            in_valid = garbage;
            in_data  = garbage ? {16'($urandom), 16'($urandom), 16'($urandom)} : '0;
            if (rel == reset_rel) begin
                #2 reset_n = 1'b0;
                #1;
                chk("rst_in_ready", in_ready, 1);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_sa", {sa_a, sa_b, sa_reset_counter}, 0);
                chk("rst_busy", busy, 0);
                in_valid = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
            if (rel == 1) begin
                chk("feed_in_ready", in_ready, 0);
                chk("feed_busy", busy, 1);
            end
            if (rel <= 2*S - 1) begin
                chk($sformatf("feed_a_k%0d", rel-1), sa_a, feed_exp(rel-1, 0));
                chk($sformatf("feed_b_k%0d", rel-1), sa_b, feed_exp(rel-1, 1));
                chk($sformatf("feed_rc_k%0d", rel-1), sa_reset_counter, (rel == 1));
            end else begin
                chk("quiet_ab", {sa_a, sa_b, sa_reset_counter}, 0);
                chk("quiet_out_valid", out_valid, 0);
            end
            if (rel > 2*S - 1 + DC) exp_row[rel - (2*S + DC)] = sa_c;
        end
        r  = 0;
        oc = 0;
        while (r < S && oc < 50) begin
            step();
            oc++;
            if (oc == 1) chk("latency_valid", out_valid, 1);
            chk("out_valid", out_valid, 1);
            chk($sformatf("out_row%0d", r), out_data, exp_row[r]);
            out_ready = (oc > stall);
            in_valid  = garbage;
            in_data   = garbage ? {16'($urandom), 16'($urandom), 16'($urandom)} : '0;
            if (out_ready && out_valid) r++;
        end
        chk("out_rows", r, S);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("back_in_ready", in_ready, 1);
        chk("back_out_valid", out_valid, 0);
        chk("back_busy", busy, 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        sa_c      = '0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sa", {sa_a, sa_b, sa_reset_counter}, 0);
        chk("reset_busy", busy, 0);
        reset_n = 1'b1;

        run_tile(1, 0, 0, 0, 0);
        chk("directed_k2", feed_exp(2, 0), pack_row(16'd3, 16'd5, 16'd7));
        run_tile(0, 1, 0, 0, 0);
        run_tile(0, 0, 0, 5, 0);
        run_tile(0, 0, 0, 0, 2*S - 1 + 2);
        run_tile(0, 0, 0, 0, 0);
        run_tile(0, 0, 1, 2, 0);
        run_tile(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            run_tile(0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $urandom_range(0, 3), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
